// File: rtl/mask_inv_pipe.sv
// rtl/mask_inv_pipe.sv - XOR-mask stream stage with 2-entry skid buffer and transfer counter
// Optional out_parity output enabled by defining MASK_INV_PIPE_PARITY_EN.
module mask_inv_pipe #(
  parameter int unsigned     N        = 4,
  parameter logic [N-1:0]    MASK_RST = N'(4'b0101)
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  input  logic         mask_we,
  input  logic [N-1:0] mask_wdata,
  output logic [N-1:0] mask_q,
`ifdef MASK_INV_PIPE_PARITY_EN
  output logic         out_parity,
`endif
  output logic [15:0]  xfer_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] skid_data;
  logic [N-1:0] word;
  logic         in_xfer;
  logic         out_xfer;

  // mask_q is read before any same-cycle write lands, so a write affects later captures only
  assign word     = in_data ^ mask_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef MASK_INV_PIPE_PARITY_EN
  logic skid_parity;
  logic word_parity;

  assign word_parity = ^word;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_parity  <= 1'b0;
      skid_parity <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (in_xfer) out_parity <= word_parity;
        ONE: begin
          if (in_xfer && out_xfer)  out_parity  <= word_parity;
          if (in_xfer && !out_xfer) skid_parity <= word_parity;
        end
        FULL: if (out_xfer) out_parity <= skid_parity;
        default: ;
      endcase
    end
  end
`endif

  // in_ready is a register driven from the next state, so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            out_data  <= word;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          in_ready <= 1'b1;
          case ({in_xfer, out_xfer})
            2'b11: out_data <= word;
            2'b10: begin
              skid_data <= word;
              in_ready  <= 1'b0;
              state     <= FULL;
            end
            2'b01: begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          in_ready <= 1'b0;
          if (out_xfer) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mask_q <= MASK_RST;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      xfer_count <= 16'h0000;
    end else if (out_xfer) begin
      xfer_count <= xfer_count + 16'h0001;
    end
  end

endmodule
